// File: rtl/key_event.sv
// key_event: debounces synchronized key levels, arbitrates commits lowest-index-first,
// and queues 8-bit press/release event codes in a CPU-drained FIFO.
module key_event #(
    parameter int DATA_WIDTH      = 8,
    parameter int KEY_WIDTH       = 6,
    parameter int INDEX_WIDTH     = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key_in,
    output logic [KEY_WIDTH-1:0]  key_state,
    output logic [DATA_WIDTH-1:0] event_data,
    output logic                  event_valid,
    input  logic                  event_pop,
    output logic                  overflow,
    input  logic                  clear_overflow
);
    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [CW-1:0]              TERM   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]              CNT1   = CW'(1);
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR1   = FIFO_DEPTH_BITS'(1);
    localparam logic [FIFO_DEPTH_BITS:0]   OCC1   = (FIFO_DEPTH_BITS + 1)'(1);
    localparam logic [FIFO_DEPTH_BITS:0]   OCCMAX = (FIFO_DEPTH_BITS + 1)'(DEPTH);

    logic [KEY_WIDTH-1:0]       state_q, state_d, elig;
    logic [CW-1:0]              cnt_q [KEY_WIDTH];
    logic [CW-1:0]              cnt_d [KEY_WIDTH];
    logic [INDEX_WIDTH-1:0]     gnt_idx;
    logic                       gnt;
    logic [DATA_WIDTH-1:0]      ev;
    logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
    logic                       valid_q, valid_d, ovf_q, ovf_d;
    logic                       full, pop_ok, push_ok, drop;

    // A key is eligible only while its input still disagrees on the grant edge.
    always_comb begin
        elig    = '0;
        gnt     = 1'b0;
        gnt_idx = '0;
        for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
            elig[i] = (key_in[i] != state_q[i]) && (cnt_q[i] == TERM);
            if (elig[i]) begin
                gnt     = 1'b1;
                gnt_idx = INDEX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (gnt) state_d[gnt_idx] = ~state_q[gnt_idx];
        for (int i = 0; i < KEY_WIDTH; i++) begin
            cnt_d[i] = (key_in[i] == state_q[i] || (gnt && gnt_idx == INDEX_WIDTH'(i))) ? '0 :
                       (cnt_q[i] == TERM) ? TERM : cnt_q[i] + CNT1;
        end
        ev = '0;
        ev[DATA_WIDTH-1] = ~state_q[gnt_idx];
        ev[INDEX_WIDTH-1:0] = gnt_idx;
    end

    always_comb begin
        full    = (count_q == OCCMAX);
        pop_ok  = event_pop && valid_q;
        push_ok = gnt && (!full || pop_ok);
        drop    = gnt && full && !pop_ok;
        count_d = (push_ok && !pop_ok) ? count_q + OCC1 :
                  (pop_ok && !push_ok) ? count_q - OCC1 : count_q;
        valid_d = (count_d != '0);
        wptr_d  = push_ok ? wptr_q + PTR1 : wptr_q;
        rptr_d  = pop_ok ? rptr_q + PTR1 : rptr_q;
        ovf_d   = drop | (ovf_q & ~clear_overflow);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < KEY_WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < KEY_WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Storage needs no reset: the head is only visible while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= ev;
    end

    assign key_state   = state_q;
    assign event_valid = valid_q;
    assign overflow    = ovf_q;
    assign event_data  = valid_q ? mem_q[rptr_q] : '0;
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed checks of debounce, arbitration, FIFO, overflow and reset.
module tb_key_event;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] key_in = '0;
    logic [5:0] key_state;
    logic [7:0] event_data;
    logic       event_valid;
    logic       event_pop = 1'b0;
    logic       overflow;
    logic       clear_overflow = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] drain_exp [8];

    key_event #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_state(key_state),
        .event_data(event_data), .event_valid(event_valid), .event_pop(event_pop),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic [5:0] st, input logic v, input logic [7:0] d, input logic ov);
        chk({tag, "_state"}, 32'(key_state), 32'(st));
        chk({tag, "_valid"}, 32'(event_valid), 32'(v));
        chk({tag, "_data"}, 32'(event_data), 32'(d));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
    endtask

    initial begin
        drain_exp = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h00, 8'h01, 8'h03};
        tick(2);
        chk_ev("rst_init", 6'h00, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        tick(6);
        chk_ev("idle", 6'h00, 1'b0, 8'h00, 1'b0);

        // single press / release of key 2
        key_in = 6'b000100;
        tick(3);
        chk_ev("press2_e3", 6'h00, 1'b0, 8'h00, 1'b0);
        tick(1);
        chk_ev("press2_e4", 6'h04, 1'b1, 8'h82, 1'b0);
        event_pop = 1'b1;
        tick(1);
        event_pop = 1'b0;
        chk_ev("pop2", 6'h04, 1'b0, 8'h00, 1'b0);
        key_in = 6'b000000;
        tick(3);
        chk_ev("rel2_e3", 6'h04, 1'b0, 8'h00, 1'b0);
        tick(1);
        chk_ev("rel2_e4", 6'h00, 1'b1, 8'h02, 1'b0);
        event_pop = 1'b1;
        tick(1);
        event_pop = 1'b0;

        // bounce on key 1
        key_in = 6'b000010;
        tick(3);
        key_in = 6'b000000;
        tick(1);
        chk_ev("bounce_glitch", 6'h00, 1'b0, 8'h00, 1'b0);
        key_in = 6'b000010;
        tick(3);
        chk_ev("bounce_e3", 6'h00, 1'b0, 8'h00, 1'b0);
        tick(1);
        chk_ev("bounce_e4", 6'h02, 1'b1, 8'h81, 1'b0);
        event_pop = 1'b1;
        tick(1);
        event_pop = 1'b0;
        key_in = 6'b000000;
        tick(4);
        chk_ev("rel1", 6'h00, 1'b1, 8'h01, 1'b0);
        event_pop = 1'b1;
        tick(1);
        event_pop = 1'b0;
        chk("empty_after_rel1", 32'(event_valid), 32'd0);

        // simultaneous keys 0 and 5
        key_in = 6'b100001;
        tick(4);
        chk_ev("simul_e4", 6'h01, 1'b1, 8'h80, 1'b0);
        tick(1);
        chk_ev("simul_e5", 6'h21, 1'b1, 8'h80, 1'b0);
        event_pop = 1'b1;
        tick(1);
        chk("simul_second", 32'(event_data), 32'h85);
        tick(1);
        event_pop = 1'b0;
        chk_ev("simul_drained", 6'h21, 1'b0, 8'h00, 1'b0);

        // overflow: reset for a clean start, then 8 events + 1 dropped
        key_in = 6'b000000;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        key_in = 6'b111111;
        tick(9);
        chk_ev("fill6", 6'h3f, 1'b1, 8'h80, 1'b0);
        key_in = 6'b111100;
        tick(5);
        chk_ev("fill8", 6'h3c, 1'b1, 8'h80, 1'b0);
        key_in = 6'b111000;
        tick(3);
        chk("ovf_before", 32'(overflow), 32'd0);
        tick(1);
        chk_ev("ovf_drop", 6'h38, 1'b1, 8'h80, 1'b1);
        tick(2);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        key_in = 6'b110000;
        tick(3);
        event_pop = 1'b1;
        tick(1);
        chk_ev("full_push_pop", 6'h30, 1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(event_data), 32'(drain_exp[i]));
            tick(1);
        end
        event_pop = 1'b0;
        chk_ev("drained", 6'h30, 1'b0, 8'h00, 1'b0);

        // pop on empty while a commit lands
        key_in = 6'b100000;
        tick(3);
        event_pop = 1'b1;
        tick(1);
        event_pop = 1'b0;
        chk_ev("pop_empty_push", 6'h20, 1'b1, 8'h04, 1'b0);

        // reset mid-debounce with 3 queued
        key_in = 6'b000000;
        tick(4);
        key_in = 6'b000001;
        tick(4);
        chk_ev("three_queued", 6'h01, 1'b1, 8'h04, 1'b0);
        key_in = 6'b000011;
        tick(2);
        #2 reset = 1'b0;
        #1;
        chk_ev("async_rst", 6'h00, 1'b0, 8'h00, 1'b0);
        key_in = 6'b000000;
        reset = 1'b1;
        tick(8);
        chk_ev("post_rst_quiet", 6'h00, 1'b0, 8'h00, 1'b0);

        // key held through reset produces a press after release
        key_in = 6'b000010;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        chk_ev("held_e3", 6'h00, 1'b0, 8'h00, 1'b0);
        tick(1);
        chk_ev("held_e4", 6'h02, 1'b1, 8'h81, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
